// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the pipeline's imem/dmem
// requesters and the memory responder.
//   master modport: the requester (fetch / memory-stage latch)
//   slave modport : the memory responder
// Signals:
//   iREN, iaddr                 instruction read request and byte address
//   ihit, iload                 instruction response pulse and word
//   dREN, dWEN, daddr, dstore   data read/write request, byte address, write data
//   dhit, dload                 data response pulse and read word
//   busy                        responder is not idle
//   memerr                      bad-address flag; present only with MEM_ERR_EN
interface mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              ihit;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dhit;
  logic [DATA_W-1:0] dload;
  logic              busy;
`ifdef MEM_ERR_EN
  logic              memerr;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  ihit, iload, dhit, dload, busy, memerr
  );
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore,
    output ihit, iload, dhit, dload, busy, memerr
  );
`else
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  ihit, iload, dhit, dload, busy
  );
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore,
    output ihit, iload, dhit, dload, busy
  );
`endif
endinterface

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder serving a read-only instruction client
// and a read/write data client from a single word array. Requests are held by
// the requester until the matching one-cycle hit. Every access waits LAT cycles
// after acceptance; data requests win over instruction fetches.
// Ports:
//   CLK   rising-edge clock
//   nRST  asynchronous active-low reset
//   bus   mem_responder_if.slave (request inputs, hit/load/busy outputs)
// Optional feature (macro MEM_ERR_EN): addresses with nonzero bits above the
// array index or a misaligned byte offset are flagged. Such reads return
// 32'hBAD1BAD1, writes are dropped, and bus.memerr pulses with the hit.
// Without the macro those bits are ignored and addresses alias.
module mem_responder #(
  parameter int    ADDR_W    = 32,
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 256,
  parameter int    LAT       = 2,
  parameter string INIT_FILE = ""
) (
  input logic           CLK,
  input logic           nRST,
  mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [DATA_W-1:0] BAD_WORD = DATA_W'(32'hBAD1BAD1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              client_d;  // latched client: 1 = data, 0 = instruction
  logic              op_wr;     // latched data op is a write
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] wdata;
  logic              bad;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef MEM_ERR_EN
  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    return ((a >> (IDX_W + 2)) != '0) || (a[1:0] != 2'b00);
  endfunction
`else
  // Upper and byte-offset address bits intentionally alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.iaddr[ADDR_W-1:IDX_W+2], bus.iaddr[1:0],
                              bus.daddr[ADDR_W-1:IDX_W+2], bus.daddr[1:0]};
  assign bad = 1'b0;
`endif

  logic dreq;
  logic req_held;
  logic commit;
  logic mem_we;

  assign dreq     = bus.dREN | bus.dWEN;
  // Abort is judged against the client that was latched, not whoever asks now.
  assign req_held = client_d ? dreq : bus.iREN;
  assign commit   = (state == WAIT) && req_held && (cnt == '0);
  assign mem_we   = commit && client_d && op_wr && !bad;

  // Array write commits on the edge that enters RESP.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[idx] <= wdata;
  end

  // Request payload captured at acceptance; later input changes are ignored.
  always_ff @(posedge CLK) begin
    if (state == IDLE) begin
      if (dreq) begin
        idx   <= bus.daddr[IDX_W+1:2];
        wdata <= bus.dstore;
      end else if (bus.iREN) begin
        idx   <= bus.iaddr[IDX_W+1:2];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      cnt      <= '0;
      client_d <= 1'b0;
      op_wr    <= 1'b0;
      bus.ihit <= 1'b0;
      bus.dhit <= 1'b0;
      bus.busy <= 1'b0;
      bus.iload <= '0;
      bus.dload <= '0;
`ifdef MEM_ERR_EN
      bad        <= 1'b0;
      bus.memerr <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (dreq) begin
            client_d <= 1'b1;
            op_wr    <= bus.dWEN;  // dREN with dWEN counts as a write
            cnt      <= CNT_W'(LAT);
            state    <= WAIT;
            bus.busy <= 1'b1;
`ifdef MEM_ERR_EN
            bad      <= addr_err(bus.daddr);
`endif
          end else if (bus.iREN) begin
            client_d <= 1'b0;
            op_wr    <= 1'b0;
            cnt      <= CNT_W'(LAT);
            state    <= WAIT;
            bus.busy <= 1'b1;
`ifdef MEM_ERR_EN
            bad      <= addr_err(bus.iaddr);
`endif
          end
        end
        // A counter of zero still costs one WAIT cycle, which keeps the
        // issue-to-issue period at LAT+3 even for LAT == 0.
        WAIT: begin
          if (!req_held) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (cnt == '0) begin
            state <= RESP;
            if (client_d) begin
              bus.dhit <= 1'b1;
              if (!op_wr) bus.dload <= bad ? BAD_WORD : mem[idx];
            end else begin
              bus.ihit  <= 1'b1;
              bus.iload <= bad ? BAD_WORD : mem[idx];
            end
`ifdef MEM_ERR_EN
            bus.memerr <= bad;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.ihit <= 1'b0;
          bus.dhit <= 1'b0;
`ifdef MEM_ERR_EN
          bus.memerr <= 1'b0;
`endif
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.ihit <= 1'b0;
          bus.dhit <= 1'b0;
        end
      endcase
    end
  end
endmodule
